// File: rtl/fft_pkg.sv
// Shared fixed-point constants and types for the radix-3^2 FFT datapath.
// TWIDDLE_CONJ_EN selects the conjugate (inverse-FFT) twiddle table.
package fft_pkg;

    localparam int DW    = 16;
    localparam int Q     = 15;
    localparam int ROUND = 1 << 14;

    localparam logic [15:0] W9_1_RE = 16'h620E;
    localparam logic [15:0] W9_1_IM = 16'hADB9;
    localparam logic [15:0] W9_2_RE = 16'h163A;
    localparam logic [15:0] W9_2_IM = 16'h81F2;
    localparam logic [15:0] W9_4_RE = 16'h87B8;
    localparam logic [15:0] W9_4_IM = 16'hD439;

    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    // Conjugating a twiddle only flips the sign of its imaginary part.
    function automatic logic [DW-1:0] tw_im(input logic [DW-1:0] im);
`ifdef TWIDDLE_CONJ_EN
        tw_im = 16'h0000 - im;
`else
        tw_im = im;
`endif
    endfunction

endpackage

// File: rtl/cmul_q15.sv
// Two-stage Q1.15 complex multiplier with exact bypass, round-half-up and
// saturation; s1_en/s2_en let the caller stall each stage independently.
module cmul_q15 #(
    parameter int DW = 16,
    parameter int PW = 2 * DW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s1_en,
    input  logic          s2_en,
    input  logic          bypass,
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_im,
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    output logic [DW-1:0] y_re,
    output logic [DW-1:0] y_im,
    output logic          sat
);
    import fft_pkg::*;

    logic signed [2*DW-1:0] ar_s, ai_s, br_s, bi_s;
    logic signed [2*DW-1:0] p_rr_s, p_ii_s, p_ri_s, p_ir_s;
    logic signed [2*DW-1:0] p_rr_r, p_ii_r, p_ri_r, p_ir_r;
    logic                   bypass_r;
    logic signed [PW-1:0]   rnd_s, sum_re_s, sum_im_s, sh_re_s, sh_im_s;
    logic [DW:0]            lim_re_s, lim_im_s;

    // Clamp a rounded sum into Q1.15; the MSB of the result flags a clip.
    function automatic logic [DW:0] sat_q15(input logic signed [PW-1:0] v);
        if (v > PW'(SAT_MAX)) begin
            sat_q15 = {1'b1, SAT_MAX};
        end else if (v < PW'(SAT_MIN)) begin
            sat_q15 = {1'b1, SAT_MIN};
        end else begin
            sat_q15 = {1'b0, v[DW-1:0]};
        end
    endfunction

    // Partial products; bypass scales the sample so rounding returns it exactly.
    always_comb begin
        ar_s = (2*DW)'(signed'(a_re));
        ai_s = (2*DW)'(signed'(a_im));
        br_s = (2*DW)'(signed'(b_re));
        bi_s = (2*DW)'(signed'(b_im));
        if (bypass) begin
            p_rr_s = ar_s <<< Q;
            p_ii_s = '0;
            p_ri_s = '0;
            p_ir_s = ai_s <<< Q;
        end else begin
            p_rr_s = ar_s * br_s;
            p_ii_s = ai_s * bi_s;
            p_ri_s = ar_s * bi_s;
            p_ir_s = ai_s * br_s;
        end
    end

    // Stage 1 register: products and bypass flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_rr_r   <= '0;
            p_ii_r   <= '0;
            p_ri_r   <= '0;
            p_ir_r   <= '0;
            bypass_r <= 1'b0;
        end else if (s1_en) begin
            p_rr_r   <= p_rr_s;
            p_ii_r   <= p_ii_s;
            p_ri_r   <= p_ri_s;
            p_ir_r   <= p_ir_s;
            bypass_r <= bypass;
        end else begin
            bypass_r <= bypass_r;
        end
    end

    // Combine, round and saturate the stage-1 products.
    always_comb begin
        rnd_s    = bypass_r ? PW'(0) : PW'(ROUND);
        sum_re_s = PW'(p_rr_r) - PW'(p_ii_r) + rnd_s;
        sum_im_s = PW'(p_ri_r) + PW'(p_ir_r) + rnd_s;
        sh_re_s  = sum_re_s >>> Q;
        sh_im_s  = sum_im_s >>> Q;
        lim_re_s = sat_q15(sh_re_s);
        lim_im_s = sat_q15(sh_im_s);
    end

    assign sat = lim_re_s[DW] | lim_im_s[DW];

    // Stage 2 register: final lane result, held while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_re <= '0;
            y_im <= '0;
        end else if (s2_en) begin
            y_re <= lim_re_s[DW-1:0];
            y_im <= lim_im_s[DW-1:0];
        end else begin
            y_im <= y_im;
        end
    end

endmodule

// File: rtl/twiddle_mult_stage.sv
// Applies W9^k to lane 1 and W9^2k to lane 2 of each radix-3 butterfly triple.
// Define TWIDDLE_CONJ_EN for the conjugate (inverse-FFT) twiddle direction.
module twiddle_mult_stage #(
    parameter int DW = 16,
    parameter int PW = 2 * DW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sof,
    input  logic [DW-1:0] x0_re,
    input  logic [DW-1:0] x0_im,
    input  logic [DW-1:0] x1_re,
    input  logic [DW-1:0] x1_im,
    input  logic [DW-1:0] x2_re,
    input  logic [DW-1:0] x2_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y0_re,
    output logic [DW-1:0] y0_im,
    output logic [DW-1:0] y1_re,
    output logic [DW-1:0] y1_im,
    output logic [DW-1:0] y2_re,
    output logic [DW-1:0] y2_im,
    output logic [1:0]    out_k,
    output logic          sat_flag
);
    import fft_pkg::*;

    logic [1:0]    k_r, k_used_s, k_next_s, s1_k_r, out_k_r;
    logic          s1_valid_r, out_valid_r, sat_flag_r;
    logic          s2_load_s, in_ready_s, in_fire_s, s1_move_s;
    logic          bypass_s, sat1_s, sat2_s;
    cplx_t         tw1_s, tw2_s;
    logic [DW-1:0] x0_re_r, x0_im_r, y0_re_r, y0_im_r;

    // Exponent 0 is never looked up: that lane runs in bypass instead.
    function automatic cplx_t twiddle(input logic [2:0] e);
        case (e)
            3'd1:    twiddle = '{re: W9_1_RE, im: tw_im(W9_1_IM)};
            3'd2:    twiddle = '{re: W9_2_RE, im: tw_im(W9_2_IM)};
            3'd4:    twiddle = '{re: W9_4_RE, im: tw_im(W9_4_IM)};
            default: twiddle = '{re: 16'h0000, im: 16'h0000};
        endcase
    endfunction

    // Twiddle index for the beat being offered and its successor.
    always_comb begin
        k_used_s = in_sof ? 2'd0 : k_r;
        if (k_used_s == 2'd2) begin
            k_next_s = 2'd0;
        end else begin
            k_next_s = k_used_s + 2'd1;
        end
        bypass_s = (k_used_s == 2'd0);
        tw1_s    = twiddle({1'b0, k_used_s});
        tw2_s    = twiddle({k_used_s, 1'b0});
    end

    // Handshake: S2 loads when empty or draining; S1 follows S2.
    always_comb begin
        s2_load_s  = !out_valid_r || out_ready;
        in_ready_s = !s1_valid_r || s2_load_s;
        in_fire_s  = in_valid && in_ready_s;
        s1_move_s  = s1_valid_r && s2_load_s;
    end

    // Control state, lane-0 delay line and sticky saturation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_r         <= 2'd0;
            s1_valid_r  <= 1'b0;
            out_valid_r <= 1'b0;
            s1_k_r      <= 2'd0;
            out_k_r     <= 2'd0;
            x0_re_r     <= '0;
            x0_im_r     <= '0;
            y0_re_r     <= '0;
            y0_im_r     <= '0;
            sat_flag_r  <= 1'b0;
        end else begin
            if (in_fire_s) begin
                k_r     <= k_next_s;
                s1_k_r  <= k_used_s;
                x0_re_r <= x0_re;
                x0_im_r <= x0_im;
            end
            if (in_ready_s) begin
                s1_valid_r <= in_valid;
            end
            if (s2_load_s) begin
                out_valid_r <= s1_valid_r;
            end
            if (s1_move_s) begin
                out_k_r    <= s1_k_r;
                y0_re_r    <= x0_re_r;
                y0_im_r    <= x0_im_r;
                sat_flag_r <= sat_flag_r | sat1_s | sat2_s;
            end
        end
    end

    cmul_q15 #(.DW(DW), .PW(PW)) u_lane1 (
        .clk    (clk),
        .rst    (rst),
        .s1_en  (in_fire_s),
        .s2_en  (s1_move_s),
        .bypass (bypass_s),
        .a_re   (x1_re),
        .a_im   (x1_im),
        .b_re   (tw1_s.re),
        .b_im   (tw1_s.im),
        .y_re   (y1_re),
        .y_im   (y1_im),
        .sat    (sat1_s)
    );

    cmul_q15 #(.DW(DW), .PW(PW)) u_lane2 (
        .clk    (clk),
        .rst    (rst),
        .s1_en  (in_fire_s),
        .s2_en  (s1_move_s),
        .bypass (bypass_s),
        .a_re   (x2_re),
        .a_im   (x2_im),
        .b_re   (tw2_s.re),
        .b_im   (tw2_s.im),
        .y_re   (y2_re),
        .y_im   (y2_im),
        .sat    (sat2_s)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_k     = out_k_r;
    assign y0_re     = y0_re_r;
    assign y0_im     = y0_im_r;
    assign sat_flag  = sat_flag_r;

endmodule

// File: tb/tb_twiddle_mult_stage.sv
// Self-checking bench for twiddle_mult_stage: directed scenarios plus random
// traffic against a queue-based arithmetic reference model.
module tb_twiddle_mult_stage;

    logic        clk, rst, in_valid, in_ready, in_sof, out_valid, out_ready, sat_flag;
    logic [15:0] x0_re, x0_im, x1_re, x1_im, x2_re, x2_im;
    logic [15:0] y0_re, y0_im, y1_re, y1_im, y2_re, y2_im;
    logic [1:0]  out_k;

    typedef struct packed {
        logic [95:0] y;
        logic [1:0]  k;
        logic        sat;
        logic [31:0] t;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] lg_y1re[$], lg_y1im[$], lg_y2re[$], lg_y2im[$];
    logic [1:0]  lg_k[$];
    int          checks = 0, failures = 0, cyc_cnt = 0, mk = 0, acc_cnt = 0;
    logic        msat = 1'b0;
    bit          lat_chk = 1'b0;

    twiddle_mult_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
        .x2_re(x2_re), .x2_im(x2_im), .out_valid(out_valid), .out_ready(out_ready),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .y2_re(y2_re), .y2_im(y2_im), .out_k(out_k), .sat_flag(sat_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Twiddle W9^e as signed integers taken from the published table.
    function automatic longint tw_re(input int e);
        case (e)
            1:       return longint'($signed(16'h620E));
            2:       return longint'($signed(16'h163A));
            default: return longint'($signed(16'h87B8));
        endcase
    endfunction

    function automatic longint tw_im(input int e);
        longint v;
        case (e)
            1:       v = longint'($signed(16'hADB9));
            2:       v = longint'($signed(16'h81F2));
            default: v = longint'($signed(16'hD439));
        endcase
`ifdef TWIDDLE_CONJ_EN
        v = -v;
`endif
        return v;
    endfunction

    function automatic longint clip(input longint v, inout logic s);
        if (v > 32767) begin s = 1'b1; return 32767; end
        if (v < -32768) begin s = 1'b1; return -32768; end
        return v;
    endfunction

    // Returns {saturated, re, im} of sample times W9^e (e=0 is identity).
    function automatic logic [32:0] mdl_mul(input logic [15:0] ar_u, input logic [15:0] ai_u, input int e);
        longint ar, ai, br, bi, re, im;
        logic   s;
        if (e == 0) return {1'b0, ar_u, ai_u};
        ar = longint'($signed(ar_u));
        ai = longint'($signed(ai_u));
        br = tw_re(e);
        bi = tw_im(e);
        s  = 1'b0;
        re = clip((ar * br - ai * bi + 16384) >>> 15, s);
        im = clip((ar * bi + ai * br + 16384) >>> 15, s);
        return {s, re[15:0], im[15:0]};
    endfunction

    task automatic accept();
        int          ku;
        exp_t        e;
        logic [32:0] r1, r2;
        ku  = in_sof ? 0 : mk;
        mk  = (ku + 1) % 3;
        r1  = mdl_mul(x1_re, x1_im, ku);
        r2  = mdl_mul(x2_re, x2_im, 2 * ku);
        msat = msat | r1[32] | r2[32];
        e.y   = {x0_re, x0_im, r1[31:0], r2[31:0]};
        e.k   = 2'(ku);
        e.sat = msat;
        e.t   = 32'(cyc_cnt);
        exp_q.push_back(e);
        acc_cnt++;
    endtask

    task automatic check_out();
        exp_t e;
        if (!out_valid) return;
        if (exp_q.size() == 0) begin
            chk("out_valid_unexpected", 32'(out_valid), 32'd0);
            return;
        end
        e = exp_q[0];
        chk("y0_re", 32'(y0_re), 32'(e.y[95:80]));
        chk("y0_im", 32'(y0_im), 32'(e.y[79:64]));
        chk("y1_re", 32'(y1_re), 32'(e.y[63:48]));
        chk("y1_im", 32'(y1_im), 32'(e.y[47:32]));
        chk("y2_re", 32'(y2_re), 32'(e.y[31:16]));
        chk("y2_im", 32'(y2_im), 32'(e.y[15:0]));
        chk("out_k", 32'(out_k), 32'(e.k));
        chk("sat_flag", 32'(sat_flag), 32'(e.sat));
        if (out_ready) begin
            if (lat_chk) chk("latency", 32'(cyc_cnt) - e.t, 32'd2);
            lg_y1re.push_back(y1_re);
            lg_y1im.push_back(y1_im);
            lg_y2re.push_back(y2_re);
            lg_y2im.push_back(y2_im);
            lg_k.push_back(out_k);
            void'(exp_q.pop_front());
        end
    endtask

    // One clock: drive handshake, score the output side, model the input side.
    task automatic cyc(input logic v, input logic sof, input logic ordy);
        in_valid  = v;
        in_sof    = sof;
        out_ready = ordy;
        #1;
        check_out();
        if (in_valid && in_ready) accept();
        @(negedge clk);
        cyc_cnt++;
    endtask

    task automatic set_x(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input logic [15:0] d, input logic [15:0] e, input logic [15:0] f);
        x0_re = a; x0_im = b; x1_re = c; x1_im = d; x2_re = e; x2_im = f;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom());
        endcase
    endfunction

    task automatic set_rand();
        set_x(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        mk = 0;
        msat = 1'b0;
        cyc_cnt++;
        #1;
    endtask

    task automatic clear_log();
        lg_y1re.delete(); lg_y1im.delete(); lg_y2re.delete(); lg_y2im.delete(); lg_k.delete();
    endtask

    initial begin
        logic [15:0] e1re[3];
        logic [15:0] e1im[3];
        logic [1:0]  eks[5];
        int          a0;

        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
        set_x(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_k", 32'(out_k), 32'd0);
        chk("rst_sat_flag", 32'(sat_flag), 32'd0);
        chk("rst_y1", {y1_re, y1_im}, 32'd0);
        chk("rst_y0y2", {y0_re ^ y2_re, y0_im | y2_im}, 32'd0);

        // Three unit-amplitude triples walk k through 0,1,2.
        clear_log();
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_x(rnd16(), rnd16(), 16'h4000, 16'h0000, 16'h4000, 16'h0000);
            cyc(1'b1, 1'b0, 1'b1);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        lat_chk = 1'b0;
        e1re = '{16'h4000, 16'h3107, 16'h0B1D};
        e1im = '{16'h0000, 16'hD6DD, 16'hC0F9};
`ifdef TWIDDLE_CONJ_EN
        e1im = '{16'h0000, 16'h2924, 16'h3F07};
`endif
        chk("dir_count", 32'(lg_k.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("dir_y1_re", 32'(lg_y1re[i]), 32'(e1re[i]));
            chk("dir_y1_im", 32'(lg_y1im[i]), 32'(e1im[i]));
            chk("dir_k", 32'(lg_k[i]), 32'(i));
        end

        // Saturation on lane 1 at k=1.
        clear_log();
        set_x(16'h0001, 16'h0002, 16'h1000, 16'h2000, 16'h0100, 16'h0200);
        cyc(1'b1, 1'b0, 1'b1);
        set_x(16'h0003, 16'h0004, 16'h7FFF, 16'h7FFF, 16'h0100, 16'h0000);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
`ifndef TWIDDLE_CONJ_EN
        chk("sat_y1_re", 32'(lg_y1re[1]), 32'h7FFF);
        chk("sat_y1_im", 32'(lg_y1im[1]), 32'h0FC7);
`endif
        chk("sat_set", 32'(sat_flag), 32'd1);
        repeat (4) cyc(1'b0, 1'b0, 1'b1);
        chk("sat_sticky", 32'(sat_flag), 32'd1);

        // Reset with two triples in flight.
        set_rand();
        cyc(1'b1, 1'b0, 1'b1);
        set_rand();
        cyc(1'b1, 1'b0, 1'b1);
        do_reset();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_k", 32'(out_k), 32'd0);
        chk("midrst_sat_flag", 32'(sat_flag), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        clear_log();
        set_rand();
        cyc(1'b1, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        chk("midrst_count", 32'(lg_k.size()), 32'd1);
        chk("midrst_next_k", 32'(lg_k[0]), 32'd0);

        // Start-of-frame on the second beat; a lone sof without valid is ignored.
        do_reset();
        clear_log();
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                set_x(rnd16(), rnd16(), rnd16(), rnd16(), 16'h4000, 16'h0000);
                cyc(1'b0, 1'b1, 1'b1);
            end else begin
                set_rand();
            end
            cyc(1'b1, (i == 1), 1'b1);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        eks = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
        chk("sof_count", 32'(lg_k.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk("sof_k", 32'(lg_k[i]), 32'(eks[i]));
        chk("sof_w4_re", 32'(lg_y2re[3]), 32'hC3DC);
`ifdef TWIDDLE_CONJ_EN
        chk("sof_w4_im", 32'(lg_y2im[3]), 32'h15E4);
`else
        chk("sof_w4_im", 32'(lg_y2im[3]), 32'hEA1D);
`endif

        // Downstream stall with continuous input.
        a0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            set_rand();
            cyc(1'b1, 1'b0, 1'b0);
        end
        chk("stall_accepted", 32'(acc_cnt - a0), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_rand();
            cyc(1'b1, 1'b0, 1'b1);
        end
        repeat (4) cyc(1'b0, 1'b0, 1'b1);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Random traffic with random backpressure and frame starts.
        for (int i = 0; i < 400; i++) begin
            set_rand();
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1'b0, 1'b0, 1'b1);
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
